// File: rtl/nibble_add_sched_if.sv
// Request/result bundle for nibble_add_sched: two add requesters, one result consumer.
interface nibble_add_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;
  logic         busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/nibble_add_sched.sv
// Two-requester adder that ripples one nibble per cycle through a single shared
// 4-bit adder, with round-robin arbitration and a held result handshake.
module fulladd4 (
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// CALC  | one nibble per cycle, LSB first, carry held in carry_q
// DONE  | result presented until the consumer takes it
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  nibble_add_sched_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;

  logic            grant;
  logic            any_valid;
  logic [3:0]      fa_a, fa_b, fa_sum;
  logic            fa_cout;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // On a tie the requester that did not win last time goes next.
  assign grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

  assign fa_a = a_q[{idx_q, 2'b00} +: 4];
  assign fa_b = b_q[{idx_q, 2'b00} +: 4];

  fulladd4 u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d          = grant ? bus.req1_a : bus.req0_a;
          b_d          = grant ? bus.req1_b : bus.req0_b;
          carry_d      = grant ? bus.req1_cin : bus.req0_cin;
          id_d         = grant;
          last_grant_d = grant;
          idx_d        = '0;
          sum_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        sum_d[{idx_q, 2'b00} +: 4] = fa_sum;
        carry_d = fa_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NIBBLES - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign bus.req0_ready = rst_n && (state_q == IDLE) && !grant;
  assign bus.req1_ready = rst_n && (state_q == IDLE) &&  grant;
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_sum    = sum_q;
  assign bus.res_cout   = carry_q;
  assign bus.res_id     = id_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched: arithmetic vectors, arbitration order,
// result hold under back-pressure and reset in the middle of a calculation.
module tb_nibble_add_sched;
  localparam int NIBBLES = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   lat;

  nibble_add_sched_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_add_sched #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one request, wait for its accept, scramble the operands, then wait for res_valid.
  task automatic send(input bit id, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, output int cycles);
    bit acc;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end
    acc = 1'b0;
    for (int k = 0; k < 30 && !acc; k++) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 16'hDEAD; bus.req0_b = 16'hBEEF; bus.req0_cin = 1'b1;
    bus.req1_a = 16'hDEAD; bus.req1_b = 16'hBEEF; bus.req1_cin = 1'b1;
    cycles = 0;
    while (!bus.res_valid && cycles < 30) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(bus.res_valid), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ids[4];
    int tms[4];
    int nacc;
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_sum", 32'(bus.res_sum), 32'd0);
    chk("rst_cout", 32'(bus.res_cout), 32'd0);
    chk("rst_id", 32'(bus.res_id), 32'd0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;

    send(1'b0, 16'h1234, 16'h0FCD, 1'b0, lat);
    chk("v1_lat", 32'(lat), 32'd4);
    chk("v1_sum", 32'(bus.res_sum), 32'h2201);
    chk("v1_cout", 32'(bus.res_cout), 32'd0);
    chk("v1_id", 32'(bus.res_id), 32'd0);
    drain();

    send(1'b1, 16'hFFFF, 16'h0001, 1'b0, lat);
    chk("v2_lat", 32'(lat), 32'd4);
    chk("v2_sum", 32'(bus.res_sum), 32'h0000);
    chk("v2_cout", 32'(bus.res_cout), 32'd1);
    chk("v2_id", 32'(bus.res_id), 32'd1);
    drain();

    send(1'b0, 16'h7FFF, 16'h0000, 1'b1, lat);
    chk("v3_sum", 32'(bus.res_sum), 32'h8000);
    chk("v3_cout", 32'(bus.res_cout), 32'd0);
    chk("v3_id", 32'(bus.res_id), 32'd0);
    drain();

    // Both requesters held valid from reset: alternating grants, NIBBLES+2 apart.
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0010; bus.req0_b = 16'h0001; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0100; bus.req1_b = 16'h0002; bus.req1_cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nacc = 0;
    for (int k = 0; k < 80 && nacc < 4; k++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        ids[nacc] = bus.req1_ready ? 1 : 0;
        tms[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("rr_count", 32'(nacc), 32'd4);
    if (nacc == 4) begin
      chk("rr_id0", 32'(ids[0]), 32'd0);
      chk("rr_id1", 32'(ids[1]), 32'd1);
      chk("rr_id2", 32'(ids[2]), 32'd0);
      chk("rr_id3", 32'(ids[3]), 32'd1);
      chk("rr_gap01", 32'(tms[1] - tms[0]), 32'(NIBBLES + 2));
      chk("rr_gap12", 32'(tms[2] - tms[1]), 32'(NIBBLES + 2));
      chk("rr_gap23", 32'(tms[3] - tms[2]), 32'(NIBBLES + 2));
    end
    repeat (10) @(posedge clk);
    #1;
    chk("rr_idle", 32'(bus.busy), 32'd0);

    // Back-pressure in DONE: result must hold while inputs churn.
    bus.res_ready = 1'b0;
    send(1'b0, 16'h00AA, 16'h0055, 1'b0, lat);
    chk("hold_lat", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 16'(16'h1111 * (k + 1)); bus.req0_b = 16'hF0F0;
      bus.req1_valid = 1'b1; bus.req1_a = 16'(16'h2222 * (k + 1)); bus.req1_b = 16'h0F0F;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_sum", 32'(bus.res_sum), 32'h00FF);
      chk("hold_id", 32'(bus.res_id), 32'd0);
      chk("hold_ready0", 32'(bus.req0_ready), 32'd0);
      chk("hold_ready1", 32'(bus.req1_ready), 32'd0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.res_ready = 1'b1;
    drain();

    // Reset after two nibbles of a calculation.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_cin = 1'b0;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 16'h0001, 16'h0002, 1'b0, lat);
    chk("post_lat", 32'(lat), 32'd4);
    chk("post_sum", 32'(bus.res_sum), 32'h0003);
    chk("post_cout", 32'(bus.res_cout), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/nibble_add_sched.md
NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES (16 at default).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 has an add request.
REQ-006 req0_ready  output  1  scheduler accepts requester 0 this cycle.
REQ-007 req0_a, req0_b  input  W each  requester 0 operands.
REQ-008 req0_cin  input  1  requester 0 carry-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer takes the result.
REQ-012 res_sum  output  W  sum, mod 2^W.
REQ-013 res_cout  output  1  carry out of the top nibble.
REQ-014 res_id  output  1  index of the requester that owns the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL compute every nibble through a single instance of the team's fulladd4 (ports sum, cout, a, b, cin), shared between both requesters.
REQ-017 FSM states SHALL be IDLE, CALC and DONE.
REQ-018 In IDLE, the grant SHALL go to the only valid requester; if both are valid, the grant SHALL go to the requester other than last_grant (round-robin).
REQ-019 reqX_ready SHALL be 1 only in IDLE, and only for the granted requester; it SHALL be 0 in CALC and DONE.
REQ-020 On a reqX_valid&&reqX_ready edge, the block SHALL latch a, b, cin and id, set last_grant=X, clear the nibble index and go to CALC.
REQ-021 In CALC, each cycle SHALL add nibble i (LSB first) of the latched operands with the carry register, write the result into sum bits [4i+3:4i], store the fulladd4 cout as the next carry, and increment i.
REQ-022 The first nibble SHALL use the latched cin as its carry-in.
REQ-023 After the edge that computes nibble NIBBLES-1, the FSM SHALL go to DONE with res_valid=1 and res_cout = final carry.
REQ-024 Latency: res_valid SHALL rise exactly NIBBLES cycles after the accept edge (4 at default).
REQ-025 In DONE, res_sum, res_cout and res_id SHALL hold stable while res_ready=0.
REQ-026 On a res_valid&&res_ready edge, the FSM SHALL return to IDLE and res_valid SHALL drop; no request is accepted on that same edge, so the next accept occurs at the earliest one cycle later.
REQ-027 Requester inputs SHALL be ignored outside IDLE; the latched operands SHALL be immune to input changes during CALC.
REQ-028 Sum arithmetic SHALL wrap mod 2^W, and overflow SHALL be reported only via res_cout.

Reset
REQ-029 While rst_n=0, asynchronously and independent of clk, the block SHALL force state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, carry=0, nibble index=0 and last_grant=1, so requester 0 wins the first tie.
REQ-030 A reset during CALC or DONE SHALL discard the partial result, and no res_valid SHALL be produced for it.
REQ-031 reqX_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 req0 a=0x1234 b=0x0FCD cin=0, res_ready=1 -> 4 cycles after accept: res_valid=1, res_sum=0x2201, res_cout=0, res_id=0.
REQ-033 req1 a=0xFFFF b=0x0001 cin=0 -> res_sum=0x0000, res_cout=1, res_id=1 (carry ripples through all nibbles).
REQ-034 req0 a=0x7FFF b=0x0000 cin=1 -> res_sum=0x8000, res_cout=0.
REQ-035 Both requesters held valid continuously after reset -> grant order is 0,1,0,1, and each accept is spaced NIBBLES+2 cycles apart with res_ready=1.
REQ-036 res_ready=0 for 5 cycles in DONE -> res_valid, res_sum and res_id stay stable, both readies stay 0, and inputs changed meanwhile do not corrupt the result.
REQ-037 rst_n pulsed low after 2 CALC nibbles -> res_valid=0 and busy=0 immediately; a following request a=0x0001 b=0x0002 completes with res_sum=0x0003.
